regwrite_arbiter: RTL

REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

---
 rtl/regwrite_arbiter_pkg.sv | 19 +
 rtl/regwrite_arbiter_if.sv | 47 ++++
 rtl/regwrite_arbiter_scoreboard.sv | 51 +++++
 rtl/regwrite_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/regwrite_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
// Holds the register-address / data widths and the priority FSM encoding
// used by the arbiter top, its scoreboard and its bus interface.
package regwrite_arbiter_pkg;

  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << REG_W;

  typedef logic [REG_W-1:0]  reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // PRIO_A: A wins a conflict; PRIO_B: B wins a conflict.
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

endpackage

// File: rtl/regwrite_arbiter_if.sv
// Bus bundle between the write requesters / register file and the arbiter.
//   AValid/AReg/AData/AReady : requester A (ALU writeback)
//   BValid/BReg/BData/BReady : requester B (load / multi-cycle unit)
//   ResValid/ResReg          : reserve a register for a future B write
//   QReg1/QReg2, Busy1/Busy2 : scoreboard query of two read addresses
//   WriteReg/WriteData/RegWrite : register file write port
// slave = arbiter side, master = requester / register file side.
interface regwrite_arbiter_if;
  import regwrite_arbiter_pkg::*;

  logic      AValid;
  reg_addr_t AReg;
  reg_data_t AData;
  logic      AReady;

  logic      BValid;
  reg_addr_t BReg;
  reg_data_t BData;
  logic      BReady;

  logic      ResValid;
  reg_addr_t ResReg;

  reg_addr_t QReg1;
  reg_addr_t QReg2;
  logic      Busy1;
  logic      Busy2;

  reg_addr_t WriteReg;
  reg_data_t WriteData;
  logic      RegWrite;

  modport slave (
    input  AValid, AReg, AData, BValid, BReg, BData,
    input  ResValid, ResReg, QReg1, QReg2,
    output AReady, BReady, Busy1, Busy2,
    output WriteReg, WriteData, RegWrite
  );

  modport master (
    output AValid, AReg, AData, BValid, BReg, BData,
    output ResValid, ResReg, QReg1, QReg2,
    input  AReady, BReady, Busy1, Busy2,
    input  WriteReg, WriteData, RegWrite
  );

endinterface

// File: rtl/regwrite_arbiter_scoreboard.sv
// Busy scoreboard: one bit per architectural register.
//   clock, reset        : clock and synchronous active-high reset
//   set_en/set_reg      : reservation (sets a bit)
//   clr_en/clr_reg      : accepted B write (clears a bit)
//   pend_en/pend_reg    : B write sitting in the output stage, not yet written
//   q_reg1/q_reg2       : query addresses
//   busy1/busy2         : query results
module regwrite_scoreboard
  import regwrite_arbiter_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      set_en,
  input  reg_addr_t set_reg,
  input  logic      clr_en,
  input  reg_addr_t clr_reg,
  input  logic      pend_en,
  input  reg_addr_t pend_reg,
  input  reg_addr_t q_reg1,
  input  reg_addr_t q_reg2,
  output logic      busy1,
  output logic      busy2
);

  logic [NUM_REGS-1:0] busy_reg;

  // Register 0 is hard-wired, so it can never be reserved.
  assign busy_reg[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
      // Set is checked first so a same-cycle reservation beats the clear.
      always_ff @(posedge clock) begin
        if (reset) begin
          busy_reg[gi] <= 1'b0;
        end else if (set_en && (set_reg == reg_addr_t'(gi))) begin
          busy_reg[gi] <= 1'b1;
        end else if (clr_en && (clr_reg == reg_addr_t'(gi))) begin
          busy_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // The bit is cleared at accept time, but the data only reaches the
  // register file one cycle later; cover that gap with the output stage.
  assign busy1 = busy_reg[q_reg1] | (pend_en && (pend_reg == q_reg1));
  assign busy2 = busy_reg[q_reg2] | (pend_en && (pend_reg == q_reg2));

endmodule

// File: rtl/regwrite_arbiter.sv
// Two-requester register-file write arbiter with starvation protection
// and a busy scoreboard for reserved (pending B) registers.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : regwrite_arbiter_if.slave (requests, readies, reservation,
//           scoreboard queries and the registered write port)
// STARVE_LIMIT (1..7): consecutive lost cycles after which B gets priority.
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input logic              clock,
  input logic              reset,
  regwrite_arbiter_if.slave bus
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  prio_t      state_reg, state_next;
  logic [2:0] starve_reg, starve_next;
  logic       a_grant, b_grant;

  logic       reg_write_reg;
  reg_addr_t  write_reg_reg;
  reg_data_t  write_data_reg;
  logic       b_flight_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= PRIO_A;
      starve_reg <= 3'd0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
    end
  end

  always_comb begin
    a_grant     = 1'b0;
    b_grant     = 1'b0;
    state_next  = state_reg;
    starve_next = starve_reg;

    if (!reset) begin
      if (bus.AValid && bus.BValid) begin
        if (state_reg == PRIO_B) b_grant = 1'b1;
        else                     a_grant = 1'b1;
      end else begin
        a_grant = bus.AValid;
        b_grant = bus.BValid;
      end
    end

    if (!bus.BValid || b_grant) begin
      starve_next = 3'd0;
    end else if (starve_reg != 3'd7) begin
      starve_next = starve_reg + 3'd1;
    end

    // Switching on the updated count makes B win on exactly the
    // (LIMIT+1)-th conflicting cycle.
    case (state_reg)
      PRIO_A:  if (starve_next >= LIMIT) state_next = PRIO_B;
      PRIO_B:  if (b_grant)              state_next = PRIO_A;
      default: state_next = PRIO_A;
    endcase
  end

  assign bus.AReady = a_grant;
  assign bus.BReady = b_grant;

  // Output stage: one cycle of latency to the register file. Writes to
  // register 0 are accepted but never asserted on the write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      reg_write_reg  <= 1'b0;
      write_reg_reg  <= '0;
      write_data_reg <= '0;
      b_flight_reg   <= 1'b0;
    end else begin
      reg_write_reg <= 1'b0;
      b_flight_reg  <= 1'b0;
      if (a_grant) begin
        write_reg_reg  <= bus.AReg;
        write_data_reg <= bus.AData;
        reg_write_reg  <= (bus.AReg != '0);
      end else if (b_grant) begin
        write_reg_reg  <= bus.BReg;
        write_data_reg <= bus.BData;
        reg_write_reg  <= (bus.BReg != '0);
        b_flight_reg   <= (bus.BReg != '0);
      end
    end
  end

  assign bus.WriteReg  = write_reg_reg;
  assign bus.WriteData = write_data_reg;
  assign bus.RegWrite  = reg_write_reg;

  regwrite_scoreboard u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .set_en   (bus.ResValid),
    .set_reg  (bus.ResReg),
    .clr_en   (b_grant),
    .clr_reg  (bus.BReg),
    .pend_en  (b_flight_reg),
    .pend_reg (write_reg_reg),
    .q_reg1   (bus.QReg1),
    .q_reg2   (bus.QReg2),
    .busy1    (bus.Busy1),
    .busy2    (bus.Busy2)
  );

endmodule
